// File: rtl/lsu_mem.sv
// Load/store unit memory stage: one data-bus access at a time, with store byte-lane
// steering, load sign/zero extension, and misalignment/bus-error reporting.
module lsu_mem (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        rd_we_i,
    input  logic [4:0]  rd_wa_i,
    input  logic [31:0] rd_wd_i,
    input  logic        csr_we_i,
    input  logic [31:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_err_i,
    output logic        rd_we_o,
    output logic [4:0]  rd_wa_o,
    output logic [31:0] rd_wd_o,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        stall_req_o,
    output logic        misaligned_load_o,
    output logic        misaligned_store_o,
    output logic        bus_err_o,
    output logic [31:0] bad_addr_o
);

    typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  size;
        logic        uns;
    } acc_t;

    state_t      state;
    acc_t        acc_q, acc_n;
    logic [31:0] ldata_q;
    logic        err_q;
    logic        access, misal, in_idle, start, mis_now;

    function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] sh;
        logic [15:0] h;
        sh = d >> {off, 3'b000};
        h  = off[1] ? d[31:16] : d[15:0];
        case (sz)
            2'b00:   fmt_load = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   fmt_load = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: fmt_load = d;
        endcase
    endfunction

    assign access  = mem_re_i | mem_we_i;
    assign misal   = (mem_size_i == 2'b01 && mem_addr_i[0]) ||
                     (mem_size_i[1] && mem_addr_i[1:0] != 2'b00);
    assign in_idle = n_rst_i && state == IDLE && access && !flush_i;
    assign start   = in_idle && !misal;
    assign mis_now = in_idle && misal;

    always_comb begin
        acc_n       = '0;
        acc_n.addr  = mem_addr_i;
        acc_n.we    = mem_we_i;
        acc_n.size  = mem_size_i;
        acc_n.uns   = mem_unsigned_i;
        case (mem_size_i)
            2'b00: begin
                acc_n.be    = 4'b0001 << mem_addr_i[1:0];
                acc_n.wdata = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                acc_n.be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                acc_n.wdata = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                acc_n.be    = 4'b1111;
                acc_n.wdata = mem_wdata_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state   <= IDLE;
            acc_q   <= '0;
            ldata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc_q <= acc_n;
                    state <= REQ;
                end
                REQ: begin
                    if (dbus_gnt_i)   state <= RESP;
                    else if (flush_i) state <= IDLE;
                end
                RESP: begin
                    if (dbus_rvalid_i) begin
                        // Stores complete on rvalid too, but never return read data.
                        ldata_q <= acc_q.we ? 32'b0 :
                                   fmt_load(dbus_rdata_i, acc_q.addr[1:0], acc_q.size, acc_q.uns);
                        err_q   <= dbus_err_i;
                        state   <= DONE;
                    end else if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: if (dbus_rvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dbus_req_o   = state == REQ;
    assign dbus_we_o    = acc_q.we;
    assign dbus_addr_o  = {acc_q.addr[31:2], 2'b00};
    assign dbus_be_o    = acc_q.be;
    assign dbus_wdata_o = acc_q.wdata;

    assign stall_req_o        = start || state == REQ || state == RESP || state == DRAIN;
    assign misaligned_load_o  = mis_now && mem_re_i;
    assign misaligned_store_o = mis_now && mem_we_i;
    assign bus_err_o          = state == DONE && err_q && !flush_i;
    assign bad_addr_o         = mis_now   ? mem_addr_i :
                                bus_err_o ? acc_q.addr : 32'b0;

    assign rd_wa_o     = rd_wa_i;
    assign rd_wd_o     = mem_re_i ? ldata_q : rd_wd_i;
    assign rd_we_o     = n_rst_i && rd_we_i && !stall_req_o && !mis_now && !bus_err_o;
    assign csr_we_o    = n_rst_i && csr_we_i && !stall_req_o && !mis_now && !bus_err_o;
    assign csr_waddr_o = csr_waddr_i;
    assign csr_wdata_o = csr_wdata_i;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: inputs change 1 time unit after the rising edge,
// outputs are compared 1 unit later, well away from either clock edge.
module tb_lsu_mem;
    logic        clk_i = 1'b0, n_rst_i = 1'b0;
    logic        rd_we_i, csr_we_i, mem_re_i, mem_we_i, mem_unsigned_i, flush_i;
    logic [4:0]  rd_wa_i;
    logic [31:0] rd_wd_i, csr_waddr_i, csr_wdata_i, mem_addr_i, mem_wdata_i;
    logic [1:0]  mem_size_i;
    logic        dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
    logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
    logic [3:0]  dbus_be_o;
    logic        rd_we_o, csr_we_o, stall_req_o, misaligned_load_o, misaligned_store_o, bus_err_o;
    logic [4:0]  rd_wa_o;
    logic [31:0] rd_wd_o, csr_waddr_o, csr_wdata_o, bad_addr_o;

    int total = 0, passed = 0, failed = 0;

    lsu_mem dut (
        .clk_i(clk_i), .n_rst_i(n_rst_i),
        .rd_we_i(rd_we_i), .rd_wa_i(rd_wa_i), .rd_wd_i(rd_wd_i),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
        .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i),
        .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i),
        .rd_we_o(rd_we_o), .rd_wa_o(rd_wa_o), .rd_wd_o(rd_wd_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .stall_req_o(stall_req_o), .misaligned_load_o(misaligned_load_o),
        .misaligned_store_o(misaligned_store_o), .bus_err_o(bus_err_o), .bad_addr_o(bad_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        rd_we_i = 0; rd_wa_i = 0; rd_wd_i = 0;
        csr_we_i = 0; csr_waddr_i = 0; csr_wdata_i = 0;
        mem_re_i = 0; mem_we_i = 0; mem_size_i = 0; mem_unsigned_i = 0;
        mem_addr_i = 0; mem_wdata_i = 0; flush_i = 0;
        dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = 0; dbus_err_i = 0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        mem_re_i = 1; mem_we_i = 0; mem_addr_i = a; mem_size_i = sz; mem_unsigned_i = uns;
        rd_we_i = 1; rd_wa_i = 5'd7; rd_wd_i = 32'h0000DEAD;
    endtask

    initial begin
        idle_inputs();
        // reset with an aligned load presented: nothing may leak out
        load(32'h0000_1000, 2'b10, 0);
        #3;
        chk("rst_req", dbus_req_o, 0);
        chk("rst_stall", stall_req_o, 0);
        chk("rst_be", dbus_be_o, 0);
        chk("rst_addr", dbus_addr_o, 0);
        chk("rst_bad", bad_addr_o, 0);
        chk("rst_rdwe", rd_we_o, 0);
        idle_inputs();
        step(); step();
        n_rst_i = 1;
        step();

        // lb 0x1003, gnt immediate, rvalid next cycle
        load(32'h0000_1003, 2'b00, 0);
        #1;
        chk("lb_idle_stall", stall_req_o, 1);
        chk("lb_idle_req", dbus_req_o, 0);
        chk("lb_idle_rdwe", rd_we_o, 0);
        step();
        dbus_gnt_i = 1;
        #1;
        chk("lb_req", dbus_req_o, 1);
        chk("lb_addr", dbus_addr_o, 32'h0000_1000);
        chk("lb_be", dbus_be_o, 4'b1000);
        chk("lb_we", dbus_we_o, 0);
        chk("lb_req_stall", stall_req_o, 1);
        step();
        dbus_gnt_i = 0; dbus_rvalid_i = 1; dbus_rdata_i = 32'h8012_3456;
        #1;
        chk("lb_resp_stall", stall_req_o, 1);
        chk("lb_resp_req", dbus_req_o, 0);
        step();
        dbus_rvalid_i = 0;
        #1;
        chk("lb_done_stall", stall_req_o, 0);
        chk("lb_done_wd", rd_wd_o, 32'hFFFF_FF80);
        chk("lb_done_rdwe", rd_we_o, 1);
        chk("lb_done_rdwa", rd_wa_o, 5'd7);
        step();
        idle_inputs();
        #1;
        chk("lb_after_stall", stall_req_o, 0);
        chk("lb_after_wd", rd_wd_o, 0);

        // sh 0x2002, grant after 3 waiting cycles
        mem_we_i = 1; mem_size_i = 2'b01; mem_addr_i = 32'h0000_2002; mem_wdata_i = 32'h0000_BEEF;
        step();
        for (int i = 0; i < 4; i++) begin
            dbus_gnt_i = (i == 3);
            #1;
            chk("sh_req_held", dbus_req_o, 1);
            chk("sh_stall", stall_req_o, 1);
            step();
        end
        dbus_gnt_i = 0;
        chk("sh_be", dbus_be_o, 4'b1100);
        chk("sh_wdata", dbus_wdata_o, 32'hBEEF_BEEF);
        chk("sh_we", dbus_we_o, 1);
        chk("sh_addr", dbus_addr_o, 32'h0000_2000);
        chk("sh_resp_req", dbus_req_o, 0);
        dbus_rvalid_i = 1; dbus_rdata_i = 32'hFFFF_FFFF;
        step();
        dbus_rvalid_i = 0;
        #1;
        chk("sh_done_stall", stall_req_o, 0);
        chk("sh_done_err", bus_err_o, 0);
        step();
        idle_inputs();

        // misaligned lw 0x3001
        load(32'h0000_3001, 2'b10, 0);
        #1;
        chk("mlw_req", dbus_req_o, 0);
        chk("mlw_flag", misaligned_load_o, 1);
        chk("mlw_sflag", misaligned_store_o, 0);
        chk("mlw_bad", bad_addr_o, 32'h0000_3001);
        chk("mlw_stall", stall_req_o, 0);
        chk("mlw_rdwe", rd_we_o, 0);
        step();
        chk("mlw_next_req", dbus_req_o, 0);
        // same access under flush: flags suppressed
        flush_i = 1;
        #1;
        chk("mlw_flush_flag", misaligned_load_o, 0);
        chk("mlw_flush_bad", bad_addr_o, 0);
        idle_inputs();
        // size 11 store at 0x5002 counts as misaligned word
        mem_we_i = 1; mem_size_i = 2'b11; mem_addr_i = 32'h0000_5002;
        #1;
        chk("msw_flag", misaligned_store_o, 1);
        chk("msw_bad", bad_addr_o, 32'h0000_5002);
        chk("msw_stall", stall_req_o, 0);
        step();
        chk("msw_req", dbus_req_o, 0);
        idle_inputs();

        // lhu 0x4000 returning a bus error
        load(32'h0000_4000, 2'b01, 1);
        step();
        dbus_gnt_i = 1;
        step();
        dbus_gnt_i = 0; dbus_rvalid_i = 1; dbus_err_i = 1; dbus_rdata_i = 32'hFFFF_8001;
        step();
        dbus_rvalid_i = 0; dbus_err_i = 0;
        #1;
        chk("lhu_err", bus_err_o, 1);
        chk("lhu_bad", bad_addr_o, 32'h0000_4000);
        chk("lhu_rdwe", rd_we_o, 0);
        chk("lhu_stall", stall_req_o, 0);
        chk("lhu_wd", rd_wd_o, 32'h0000_8001);
        step();
        idle_inputs();
        #1;
        chk("lhu_after_err", bus_err_o, 0);

        // lh 0x6002, upper half sign-extended
        load(32'h0000_6002, 2'b01, 0);
        step();
        dbus_gnt_i = 1;
        chk("lh_be", dbus_be_o, 4'b1100);
        step();
        dbus_gnt_i = 0; dbus_rvalid_i = 1; dbus_rdata_i = 32'hABCD_1234;
        step();
        dbus_rvalid_i = 0;
        #1;
        chk("lh_wd", rd_wd_o, 32'hFFFF_ABCD);
        chk("lh_rdwe", rd_we_o, 1);
        step();
        idle_inputs();

        // lw granted, flush in RESP, rvalid two cycles later
        load(32'h0000_7000, 2'b10, 0);
        step();
        dbus_gnt_i = 1;
        step();
        dbus_gnt_i = 0; flush_i = 1;
        #1;
        chk("fl_resp_stall", stall_req_o, 1);
        step();
        idle_inputs();
        rd_we_i = 1;
        #1;
        chk("fl_drain_stall", stall_req_o, 1);
        chk("fl_drain_rdwe", rd_we_o, 0);
        chk("fl_drain_req", dbus_req_o, 0);
        step();
        dbus_rvalid_i = 1; dbus_err_i = 1; dbus_rdata_i = 32'h1234_5678;
        #1;
        chk("fl_drain2_stall", stall_req_o, 1);
        chk("fl_drain2_rdwe", rd_we_o, 0);
        step();
        idle_inputs();
        #1;
        chk("fl_idle_stall", stall_req_o, 0);
        chk("fl_idle_err", bus_err_o, 0);
        chk("fl_idle_req", dbus_req_o, 0);

        // reset asserted in RESP
        load(32'h0000_8000, 2'b10, 0);
        step();
        dbus_gnt_i = 1;
        step();
        dbus_gnt_i = 0;
        n_rst_i = 0;
        #1;
        chk("rr_req", dbus_req_o, 0);
        chk("rr_stall", stall_req_o, 0);
        chk("rr_be", dbus_be_o, 0);
        chk("rr_addr", dbus_addr_o, 0);
        chk("rr_rdwe", rd_we_o, 0);
        step();
        idle_inputs();
        n_rst_i = 1;
        dbus_rvalid_i = 1; dbus_err_i = 1; dbus_rdata_i = 32'hCAFE_F00D;
        #1;
        chk("rr_late_stall", stall_req_o, 0);
        step();
        dbus_rvalid_i = 0; dbus_err_i = 0;
        #1;
        chk("rr_late_err", bus_err_o, 0);
        chk("rr_late_req", dbus_req_o, 0);
        // machine is back in IDLE and accepts a fresh access
        load(32'h0000_9000, 2'b00, 0);
        step();
        chk("rr_new_req", dbus_req_o, 1);
        chk("rr_new_addr", dbus_addr_o, 32'h0000_9000);
        chk("rr_new_be", dbus_be_o, 4'b0001);
        idle_inputs();
        dbus_gnt_i = 1;
        step();
        dbus_gnt_i = 0; dbus_rvalid_i = 1;
        step();
        dbus_rvalid_i = 0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
